stream_demux_1x2: RTL

- Sequential 1-to-2 stream demultiplexer: the distribution-side counterpart of the 2:1 selection mux.
- Takes one valid/ready byte stream and steers each accepted beat to output A or output B.
- Each output has a one-entry register stage.
- Used to split row streams in the 10x10 8-bit datapath, either by explicit select or by ping-ponging whole bursts (rows) between two consumers.

---
 rtl/stream_demux_1x2.sv | 121 ++++++++++++
 1 files changed

// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2
//   1-to-2 valid/ready stream demultiplexer. Each accepted input beat is
//   steered to output A or B and held in that output's one-entry register
//   stage until its consumer takes it.
//
//   Routing is either explicit per beat (selMode=0, target = sel) or
//   burst ping-pong (selMode=1): whole bursts of BURST_LEN beats alternate
//   between A and B. The mode is sampled at the first beat of a burst and
//   held until the burst completes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inData/inValid/inReady   input stream (inReady is combinational)
//   selMode, sel             routing mode and explicit route select
//   outData_A/outValid_A/outReady_A   output stream A
//   outData_B/outValid_B/outReady_B   output stream B
//   burstDone                registered pulse: last beat of a burst accepted
//   activeSel                current routing target (0 = A, 1 = B)
module stream_demux_1x2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 10,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  selMode,
  input  logic                  sel,
  output logic [DATA_WIDTH-1:0] outData_A,
  output logic                  outValid_A,
  input  logic                  outReady_A,
  output logic [DATA_WIDTH-1:0] outData_B,
  output logic                  outValid_B,
  input  logic                  outReady_B,
  output logic                  burstDone,
  output logic                  activeSel
);

  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 ping_sel;
  logic                 mode_latched;

  logic cnt_zero;
  logic eff_mode;
  logic target;
  logic accept;
  logic last_beat;
  logic wr_a;
  logic wr_b;

  always_comb begin
    cnt_zero  = (beat_cnt == '0);
    // A mode change only takes effect at a burst boundary.
    eff_mode  = cnt_zero ? selMode : mode_latched;
    target    = eff_mode ? ping_sel : sel;
    // Only the target stage gates acceptance, so a stalled consumer on one
    // side never blocks traffic routed to the other.
    inReady   = target ? (!outValid_B || outReady_B)
                       : (!outValid_A || outReady_A);
    accept    = inValid && inReady;
    last_beat = (beat_cnt == CNT_WIDTH'(BURST_LEN - 1));
    wr_a      = accept && !target;
    wr_b      = accept &&  target;
  end

  assign activeSel = target;

  // Output stage A: a write wins over a drain, so drain+write keeps valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_A <= 1'b0;
      outData_A  <= '0;
    end else if (wr_a) begin
      outValid_A <= 1'b1;
      outData_A  <= inData;
    end else if (outReady_A) begin
      outValid_A <= 1'b0;
    end
  end

  // Output stage B.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_B <= 1'b0;
      outData_B  <= '0;
    end else if (wr_b) begin
      outValid_B <= 1'b1;
      outData_B  <= inData;
    end else if (outReady_B) begin
      outValid_B <= 1'b0;
    end
  end

  // Beat counter, ping-pong selector and burst-mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt     <= '0;
      ping_sel     <= 1'b0;
      mode_latched <= 1'b0;
      burstDone    <= 1'b0;
    end else begin
      burstDone <= accept && last_beat;
      if (cnt_zero) begin
        mode_latched <= selMode;
      end
      if (accept) begin
        if (last_beat) begin
          beat_cnt <= '0;
          if (eff_mode) begin
            ping_sel <= !ping_sel;
          end
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule
